ysyx_25030081_lsu: RTL and testbench

YSYX_25030081_LSU -- requirements
Module: ysyx_25030081_lsu

---
 rtl/ysyx_25030081_lsu.sv | 139 +++++++++++++
 tb/tb_ysyx_25030081_lsu.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_25030081_lsu.sv
// Load/store unit: turns one core memory op into one word-aligned bus transaction.
// Store lanes are replicated onto the bus; loads are shifted and extended on return.
module ysyx_25030081_lsu (
  input  logic        clk,
  input  logic        rst_n,
  // core request / response
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_ren,
  input  logic        req_wen,
  input  logic [2:0]  req_mem_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  // memory bus
  output logic        bus_req_valid,
  input  logic        bus_req_ready,
  output logic [31:0] bus_addr,
  output logic        bus_wen,
  output logic [3:0]  bus_wmask,
  output logic [31:0] bus_wdata,
  input  logic        bus_rsp_valid,
  input  logic [31:0] bus_rsp_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  state_t      state, state_nxt;

  logic        accept;
  logic        is_byte, is_half, is_word;
  logic        op_illegal, access, req_err, go_bus;
  logic [3:0]  st_mask;
  logic [31:0] st_data;

  logic        err_q, ren_q;
  logic [2:0]  op_q;
  logic [1:0]  off_q;
  logic [31:0] rdata_q;
  logic [31:0] bus_addr_q, bus_wdata_q;
  logic        bus_wen_q;
  logic [3:0]  bus_wmask_q;

  logic [31:0] shifted;
  logic [31:0] load_ext;

  assign accept     = req_valid & (state == IDLE);
  assign is_byte    = (req_mem_op[1:0] == 2'b00);
  assign is_half    = (req_mem_op[1:0] == 2'b01);
  assign is_word    = (req_mem_op[1:0] == 2'b10);
  assign op_illegal = (req_mem_op == 3'b011) | (req_mem_op == 3'b110) | (req_mem_op == 3'b111);
  assign access     = req_ren | req_wen;

  // Opcode and alignment are only judged for real accesses: a non-memory
  // instruction arrives with whatever mem_op the decoder left behind.
  assign req_err = (req_ren & req_wen)
                 | (access & (op_illegal
                              | (req_wen & req_mem_op[2])
                              | (is_half & req_addr[0])
                              | (is_word & (req_addr[1:0] != 2'b00))));
  assign go_bus  = access & ~req_err;

  assign st_mask = is_byte ? (4'b0001 << req_addr[1:0])
                 : is_half ? (req_addr[1] ? 4'b1100 : 4'b0011)
                 :           4'b1111;
  assign st_data = is_byte ? {4{req_wdata[7:0]}}
                 : is_half ? {2{req_wdata[15:0]}}
                 :           req_wdata;

  assign shifted = bus_rsp_rdata >> {off_q, 3'b000};
  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    load_ext = shifted;
    case (op_q[1:0])
      2'b00:   load_ext = {{24{~op_q[2] & shifted[7]}},  shifted[7:0]};
      2'b01:   load_ext = {{16{~op_q[2] & shifted[15]}}, shifted[15:0]};
      default: load_ext = shifted;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = go_bus ? REQ : RESP;
      REQ:  if (bus_req_ready) state_nxt = WAIT;
      WAIT: if (bus_rsp_valid) state_nxt = RESP;
      RESP: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: the datapath registers are reset too, because the bus fields are visible outputs with defined reset values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q       <= 1'b0;
      ren_q       <= 1'b0;
      op_q        <= 3'b000;
      off_q       <= 2'b00;
      rdata_q     <= 32'h0;
      bus_addr_q  <= 32'h0;
      bus_wen_q   <= 1'b0;
      bus_wmask_q <= 4'b0000;
      bus_wdata_q <= 32'h0;
    end else if (accept) begin
      err_q       <= req_err;
      ren_q       <= req_ren & go_bus;
      op_q        <= req_mem_op;
      off_q       <= req_addr[1:0];
      rdata_q     <= 32'h0;
      if (go_bus) begin
        bus_addr_q  <= {req_addr[31:2], 2'b00};
        bus_wen_q   <= req_wen;
        bus_wmask_q <= req_wen ? st_mask : 4'b0000;
        bus_wdata_q <= req_wen ? st_data : 32'h0;
      end
    end else if ((state == WAIT) && bus_rsp_valid && ren_q) begin
      rdata_q <= load_ext;
    end
  end

  assign req_ready     = (state == IDLE);
  assign bus_req_valid = (state == REQ);
  assign bus_addr      = bus_addr_q;
  assign bus_wen       = bus_wen_q;
  assign bus_wmask     = bus_wmask_q;
  assign bus_wdata     = bus_wdata_q;
  assign resp_valid    = (state == RESP);
  assign resp_err      = resp_valid & err_q;
  assign resp_rdata    = resp_valid ? rdata_q : 32'h0;

endmodule

// File: tb/tb_ysyx_25030081_lsu.sv
// Directed bench for ysyx_25030081_lsu: inputs change and outputs are sampled
// on the falling edge, so each negedge sees the state settled by the prior rise.
module tb_ysyx_25030081_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_ren, req_wen;
  logic [2:0]  req_mem_op;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic        bus_req_valid, bus_req_ready, bus_wen;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_wmask;
  logic        bus_rsp_valid;
  logic [31:0] bus_rsp_rdata;

  int checks = 0;
  int errors = 0;

  ysyx_25030081_lsu dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_ren       (req_ren),
    .req_wen       (req_wen),
    .req_mem_op    (req_mem_op),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .resp_valid    (resp_valid),
    .resp_rdata    (resp_rdata),
    .resp_err      (resp_err),
    .bus_req_valid (bus_req_valid),
    .bus_req_ready (bus_req_ready),
    .bus_addr      (bus_addr),
    .bus_wen       (bus_wen),
    .bus_wmask     (bus_wmask),
    .bus_wdata     (bus_wdata),
    .bus_rsp_valid (bus_rsp_valid),
    .bus_rsp_rdata (bus_rsp_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic drive_req(input logic ren, input logic wen, input logic [2:0] op,
                           input logic [31:0] addr, input logic [31:0] wdata);
    @(negedge clk);
    req_valid  = 1'b1;
    req_ren    = ren;
    req_wen    = wen;
    req_mem_op = op;
    req_addr   = addr;
    req_wdata  = wdata;
  endtask

  // Zero-wait bus transaction: accept T, bus request T+1, bus response T+2, resp T+3.
  task automatic bus_op(input string tag, input logic ren, input logic wen, input logic [2:0] op,
                        input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] brdata,
                        input logic [31:0] exp_addr, input logic [3:0] exp_mask,
                        input logic [31:0] exp_bdata, input logic [31:0] exp_rdata);
    drive_req(ren, wen, op, addr, wdata);
    check({tag, ".req_ready@T"}, 32'(req_ready), 32'h1);
    @(negedge clk);
    req_valid = 1'b0;
    check({tag, ".bus_req_valid@T+1"}, 32'(bus_req_valid), 32'h1);
    check({tag, ".bus_addr"}, bus_addr, exp_addr);
    check({tag, ".bus_wen"}, 32'(bus_wen), 32'(wen));
    check({tag, ".bus_wmask"}, 32'(bus_wmask), 32'(exp_mask));
    if (wen) check({tag, ".bus_wdata"}, bus_wdata, exp_bdata);
    check({tag, ".req_ready@T+1"}, 32'(req_ready), 32'h0);
    @(negedge clk);
    check({tag, ".bus_req_valid@T+2"}, 32'(bus_req_valid), 32'h0);
    check({tag, ".resp_valid@T+2"}, 32'(resp_valid), 32'h0);
    bus_rsp_valid = 1'b1;
    bus_rsp_rdata = brdata;
    @(negedge clk);
    bus_rsp_valid = 1'b0;
    check({tag, ".resp_valid@T+3"}, 32'(resp_valid), 32'h1);
    check({tag, ".resp_err"}, 32'(resp_err), 32'h0);
    check({tag, ".resp_rdata"}, resp_rdata, exp_rdata);
    @(negedge clk);
    check({tag, ".resp_valid@T+4"}, 32'(resp_valid), 32'h0);
    check({tag, ".req_ready@T+4"}, 32'(req_ready), 32'h1);
  endtask

  // Op resolved without the bus: resp in T+1, bus_req_valid never raised.
  task automatic local_op(input string tag, input logic ren, input logic wen, input logic [2:0] op,
                          input logic [31:0] addr, input logic exp_err);
    drive_req(ren, wen, op, addr, 32'h5555_AAAA);
    @(negedge clk);
    req_valid = 1'b0;
    check({tag, ".resp_valid@T+1"}, 32'(resp_valid), 32'h1);
    check({tag, ".resp_err"}, 32'(resp_err), 32'(exp_err));
    check({tag, ".resp_rdata"}, resp_rdata, 32'h0);
    check({tag, ".bus_req_valid@T+1"}, 32'(bus_req_valid), 32'h0);
    @(negedge clk);
    check({tag, ".bus_req_valid@T+2"}, 32'(bus_req_valid), 32'h0);
    check({tag, ".resp_valid@T+2"}, 32'(resp_valid), 32'h0);
    check({tag, ".req_ready@T+2"}, 32'(req_ready), 32'h1);
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = 1'b0; req_ren = 1'b0; req_wen = 1'b0; req_mem_op = 3'b000;
    req_addr = 32'h0; req_wdata = 32'h0;
    bus_req_ready = 1'b1; bus_rsp_valid = 1'b0; bus_rsp_rdata = 32'h0;

    // Reset values
    #12;
    check("rst.req_ready", 32'(req_ready), 32'h1);
    check("rst.resp_valid", 32'(resp_valid), 32'h0);
    check("rst.resp_err", 32'(resp_err), 32'h0);
    check("rst.resp_rdata", resp_rdata, 32'h0);
    check("rst.bus_req_valid", 32'(bus_req_valid), 32'h0);
    check("rst.bus_wen", 32'(bus_wen), 32'h0);
    check("rst.bus_wmask", 32'(bus_wmask), 32'h0);
    check("rst.bus_addr", bus_addr, 32'h0);
    check("rst.bus_wdata", bus_wdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Loads
    bus_op("lb",  1'b1, 1'b0, 3'b000, 32'h8000_0003, 32'h0, 32'h80AA_BBCC, 32'h8000_0000, 4'h0, 32'h0, 32'hFFFF_FF80);
    bus_op("lhu", 1'b1, 1'b0, 3'b101, 32'h8000_0002, 32'h0, 32'h9ABC_1234, 32'h8000_0000, 4'h0, 32'h0, 32'h0000_9ABC);
    bus_op("lh",  1'b1, 1'b0, 3'b001, 32'h8000_0002, 32'h0, 32'h9ABC_1234, 32'h8000_0000, 4'h0, 32'h0, 32'hFFFF_9ABC);
    bus_op("lbu", 1'b1, 1'b0, 3'b100, 32'h8000_0101, 32'h0, 32'h80AA_BBCC, 32'h8000_0100, 4'h0, 32'h0, 32'h0000_00BB);
    bus_op("lb1", 1'b1, 1'b0, 3'b000, 32'h8000_0101, 32'h0, 32'h80AA_BBCC, 32'h8000_0100, 4'h0, 32'h0, 32'hFFFF_FFBB);
    bus_op("lh0", 1'b1, 1'b0, 3'b001, 32'h8000_0200, 32'h0, 32'h9ABC_7234, 32'h8000_0200, 4'h0, 32'h0, 32'h0000_7234);
    bus_op("lw",  1'b1, 1'b0, 3'b010, 32'h8000_0008, 32'h0, 32'h1122_3344, 32'h8000_0008, 4'h0, 32'h0, 32'h1122_3344);

    // Stores
    bus_op("sb", 1'b0, 1'b1, 3'b000, 32'h8000_0001, 32'h1234_56EF, 32'hFFFF_FFFF, 32'h8000_0000, 4'b0010, 32'hEFEF_EFEF, 32'h0);
    bus_op("sh", 1'b0, 1'b1, 3'b001, 32'h8000_0002, 32'h1234_56EF, 32'hFFFF_FFFF, 32'h8000_0000, 4'b1100, 32'h56EF_56EF, 32'h0);
    bus_op("sh0", 1'b0, 1'b1, 3'b001, 32'h8000_0000, 32'h1234_56EF, 32'h0, 32'h8000_0000, 4'b0011, 32'h56EF_56EF, 32'h0);
    bus_op("sw", 1'b0, 1'b1, 3'b010, 32'h8000_0004, 32'hDEAD_BEEF, 32'h0, 32'h8000_0004, 4'b1111, 32'hDEAD_BEEF, 32'h0);

    // Errors and no-op
    local_op("err_sw_mis", 1'b0, 1'b1, 3'b010, 32'h8000_0002, 1'b1);
    local_op("err_lh_mis", 1'b1, 1'b0, 3'b001, 32'h8000_0001, 1'b1);
    local_op("err_op011",  1'b1, 1'b0, 3'b011, 32'h8000_0000, 1'b1);
    local_op("err_op110",  1'b1, 1'b0, 3'b110, 32'h8000_0000, 1'b1);
    local_op("err_sbu",    1'b0, 1'b1, 3'b100, 32'h8000_0000, 1'b1);
    local_op("err_renwen", 1'b1, 1'b1, 3'b010, 32'h8000_0000, 1'b1);
    local_op("noop",       1'b0, 1'b0, 3'b010, 32'h8000_0000, 1'b0);

    // Backpressure: bus fields stable, stray bus response and new core request ignored
    bus_req_ready = 1'b0;
    drive_req(1'b0, 1'b1, 3'b010, 32'h8000_0010, 32'hCAFE_F00D);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      req_addr = 32'h1111_1110; req_wdata = 32'h0; req_wen = 1'b0; req_ren = 1'b1;
      bus_rsp_valid = (i == 2);
      check($sformatf("bp%0d.bus_req_valid", i), 32'(bus_req_valid), 32'h1);
      check($sformatf("bp%0d.bus_addr", i), bus_addr, 32'h8000_0010);
      check($sformatf("bp%0d.bus_wdata", i), bus_wdata, 32'hCAFE_F00D);
      check($sformatf("bp%0d.bus_wmask", i), 32'(bus_wmask), 32'hF);
      check($sformatf("bp%0d.req_ready", i), 32'(req_ready), 32'h0);
      check($sformatf("bp%0d.resp_valid", i), 32'(resp_valid), 32'h0);
    end
    req_valid = 1'b0; bus_rsp_valid = 1'b0; bus_req_ready = 1'b1;
    @(negedge clk);
    check("bp.bus_req_valid_wait", 32'(bus_req_valid), 32'h0);
    check("bp.resp_valid_wait", 32'(resp_valid), 32'h0);
    bus_rsp_valid = 1'b1; bus_rsp_rdata = 32'h7777_7777;
    @(negedge clk);
    bus_rsp_valid = 1'b0;
    check("bp.resp_valid", 32'(resp_valid), 32'h1);
    check("bp.resp_err", 32'(resp_err), 32'h0);
    check("bp.resp_rdata", resp_rdata, 32'h0);
    @(negedge clk);
    check("bp.req_ready_after", 32'(req_ready), 32'h1);

    // Reset during REQ drops bus_req_valid without waiting for a clock
    bus_req_ready = 1'b0;
    drive_req(1'b1, 1'b0, 3'b010, 32'h8000_0020, 32'h0);
    @(negedge clk);
    req_valid = 1'b0;
    check("rstreq.bus_req_valid_before", 32'(bus_req_valid), 32'h1);
    rst_n = 1'b0;
    #1;
    check("rstreq.bus_req_valid_async", 32'(bus_req_valid), 32'h0);
    check("rstreq.req_ready_async", 32'(req_ready), 32'h1);
    @(negedge clk);
    rst_n = 1'b1; bus_req_ready = 1'b1;

    // Reset during WAIT, then a late bus response is ignored
    drive_req(1'b1, 1'b0, 3'b010, 32'h8000_0020, 32'h0);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rstwait.req_ready", 32'(req_ready), 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    bus_rsp_valid = 1'b1; bus_rsp_rdata = 32'hBAD0_BAD0;
    @(negedge clk);
    bus_rsp_valid = 1'b0;
    check("rstwait.resp_valid", 32'(resp_valid), 32'h0);
    check("rstwait.req_ready_after", 32'(req_ready), 32'h1);
    @(negedge clk);
    check("rstwait.resp_valid_later", 32'(resp_valid), 32'h0);
    bus_op("lw_after_rst", 1'b1, 1'b0, 3'b010, 32'h8000_0024, 32'h0, 32'h0BAD_F00D, 32'h8000_0024, 4'h0, 32'h0, 32'h0BAD_F00D);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
